// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 3-digit common-anode seven-segment display.
// Latches one snapshot per frame and inserts an all-off gap before every digit.
module seven_segment_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       blank_leading,
    output logic [6:0] seg,
    output logic [2:0] anode,
    output logic       frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRV_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        PH_GAP   = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    phase_t        phase_q, phase_d;
    logic [1:0]    digit_q, digit_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [11:0]   snap_q,  snap_d;
    logic          blank_q, blank_d;
    logic [6:0]    seg_q,   seg_d;
    logic [2:0]    anode_q, anode_d;
    logic          tick_q,  tick_d;
    logic [9:0]    drive_d;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h3F;
        endcase
        return g;
    endfunction

    // Returns {anode, seg} for one digit slot; a blanked slot stays dark.
    function automatic logic [9:0] drive_word(input logic [11:0] snap,
                                              input logic        blank,
                                              input logic [1:0]  digit);
        logic [3:0] nib;
        logic [2:0] an;
        logic       dark;
        case (digit)
            2'd1:    begin nib = snap[7:4];  an = 3'b101; dark = blank && (snap[11:4] == 8'h00); end
            2'd2:    begin nib = snap[11:8]; an = 3'b011; dark = blank && (snap[11:8] == 4'h0);  end
            default: begin nib = snap[3:0];  an = 3'b110; dark = 1'b0;                           end
        endcase
        if (dark) begin
            return {3'b111, 7'h7F};
        end else begin
            return {an, glyph(nib)};
        end
    endfunction

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        phase_d = phase_q;
        digit_d = digit_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        blank_d = blank_q;
        seg_d   = 7'h7F;
        anode_d = 3'b111;
        tick_d  = 1'b0;
        drive_d = {3'b111, 7'h7F};
        case (phase_q)
            PH_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    phase_d = PH_DRIVE;
                    cnt_d   = '0;
                    if (digit_q == 2'd0) begin
                        snap_d  = {hundreds, tens, ones};
                        blank_d = blank_leading;
                        tick_d  = 1'b1;
                    end else begin
                        tick_d  = 1'b0;
                    end
                    drive_d = drive_word(snap_d, blank_d, digit_q);
                    anode_d = drive_d[9:7];
                    seg_d   = drive_d[6:0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PH_DRIVE: begin
                if (cnt_q == DRV_LAST) begin
                    phase_d = PH_GAP;
                    cnt_d   = '0;
                    digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    seg_d   = seg_q;
                    anode_d = anode_q;
                end
            end
            default: begin
                phase_d = PH_GAP;
                cnt_d   = '0;
                digit_d = 2'd0;
            end
        endcase
    end

    // State and output registers; reset wins over any coincident transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_GAP;
            digit_q <= 2'd0;
            cnt_q   <= '0;
            snap_q  <= 12'h000;
            blank_q <= 1'b0;
            seg_q   <= 7'h7F;
            anode_q <= 3'b111;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign anode      = anode_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: frame-position reference model checked every
// cycle, plus a table of display vectors and hand-written corner sequences.
module tb_seven_segment_scanner;

    localparam int R = 4;
    localparam int B = 1;
    localparam int F = 3 * (R + B);

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] ones, tens, hundreds;
    logic       blank_leading;
    logic [6:0] seg;
    logic [2:0] anode;
    logic       frame_tick;

    seven_segment_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clock(clock), .reset(reset), .ones(ones), .tens(tens),
        .hundreds(hundreds), .blank_leading(blank_leading),
        .seg(seg), .anode(anode), .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] h, t, o;
        logic       bl;
        logic [6:0] sh, st, so;
    } vec_t;

    vec_t       tbl [8];
    logic [6:0] glyph_tbl [16];
    int         n_vec = 0;
    int         n_bad = 0;
    int         t_m   = 0;
    logic [11:0] snap_m = 12'h000;
    logic        bl_m   = 1'b0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", nm, t_m, got, exp);
        end
    endtask

    // One clock: update the model from frame position, then compare all outputs.
    task automatic step();
        logic        r, b;
        logic [11:0] in;
        int          p, slot, off;
        logic [3:0]  nib;
        logic [6:0]  es;
        logic [2:0]  ea;
        logic        et;
        r  = reset;
        b  = blank_leading;
        in = {hundreds, tens, ones};
        @(posedge clock);
        #1;
        es = 7'h7F; ea = 3'b111; et = 1'b0;
        if (r) begin
            t_m = 0; snap_m = 12'h000; bl_m = 1'b0;
        end else begin
            t_m++;
            p = t_m % F;
            if (p == B) begin
                snap_m = in; bl_m = b;
            end
            slot = p / (R + B);
            off  = p % (R + B);
            if (off >= B) begin
                nib = snap_m[slot*4 +: 4];
                if (!(bl_m && ((slot == 2 && snap_m[11:8] == 4'h0) ||
                               (slot == 1 && snap_m[11:4] == 8'h00)))) begin
                    es = glyph_tbl[nib];
                    ea = ~(3'b001 << slot);
                end
                et = (slot == 0 && off == B);
            end
        end
        n_vec++;
        if ({seg, anode, frame_tick} !== {es, ea, et}) begin
            n_bad++;
            $display("FAIL model t=%0d got seg=%h anode=%b tick=%b exp seg=%h anode=%b tick=%b",
                     t_m, seg, anode, frame_tick, es, ea, et);
        end
    endtask

    task automatic step_to(input int target);
        for (int i = 0; i < F + 1; i++) begin
            step();
            if ((t_m % F) == target) break;
        end
    endtask

    task automatic set_in(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o, input logic bl);
        hundreds = h; tens = t; ones = o; blank_leading = bl;
    endtask

    initial begin
        logic [6:0] es;
        logic [2:0] ea;
        int         p, slot;
        glyph_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        tbl[0] = '{4'h1, 4'h2, 4'h3, 1'b0, 7'h79, 7'h24, 7'h30};
        tbl[1] = '{4'h0, 4'h0, 4'h7, 1'b1, 7'h7F, 7'h7F, 7'h78};
        tbl[2] = '{4'h0, 4'h0, 4'h7, 1'b0, 7'h40, 7'h40, 7'h78};
        tbl[3] = '{4'h0, 4'hA, 4'h0, 1'b1, 7'h7F, 7'h3F, 7'h40};
        tbl[4] = '{4'h9, 4'h8, 4'h5, 1'b1, 7'h10, 7'h00, 7'h12};
        tbl[5] = '{4'h0, 4'h0, 4'h0, 1'b1, 7'h7F, 7'h7F, 7'h40};
        tbl[6] = '{4'h0, 4'h5, 4'h0, 1'b1, 7'h7F, 7'h12, 7'h40};
        tbl[7] = '{4'hF, 4'h0, 4'h0, 1'b1, 7'h3F, 7'h40, 7'h40};

        reset = 1'b1;
        set_in(4'h1, 4'h2, 4'h3, 1'b0);
        step();
        step();
        chk("reset_state", {6'd0, seg, anode}, {6'd0, 7'h7F, 3'b111});
        reset = 1'b0;

        // Table vectors: each applied at frame position 0, one full frame run.
        for (int k = 0; k < 8; k++) begin
            set_in(tbl[k].h, tbl[k].t, tbl[k].o, tbl[k].bl);
            for (int c = 1; c <= F; c++) begin
                step();
                p    = t_m % F;
                slot = p / (R + B);
                if ((p % (R + B)) >= B) begin
                    es = (slot == 0) ? tbl[k].so : (slot == 1) ? tbl[k].st : tbl[k].sh;
                    ea = (es == 7'h7F) ? 3'b111 : ~(3'b001 << slot);
                    chk("table", {6'd0, es, ea} ^ 16'h0 ^ {6'd0, seg, anode} ^ {6'd0, es, ea},
                        {6'd0, es, ea});
                end
            end
        end

        // Snapshot integrity: change inputs during the tens slot.
        set_in(4'h1, 4'h2, 4'h3, 1'b0);
        step_to(6);
        set_in(4'h4, 4'h5, 4'h6, 1'b0);
        step_to(11);
        chk("snap_hold_hundreds", {6'd0, seg, anode}, {6'd0, 7'h79, 3'b011});
        step_to(1);
        chk("snap_next_ones", {6'd0, seg, anode}, {6'd0, 7'h02, 3'b110});
        step_to(0);

        // Reset during the hundreds slot.
        set_in(4'h1, 4'h2, 4'h3, 1'b0);
        step_to(11);
        reset = 1'b1;
        set_in(4'h0, 4'h0, 4'h8, 1'b0);
        step();
        chk("midreset_off", {5'd0, seg, anode, frame_tick}, {5'd0, 7'h7F, 3'b111, 1'b0});
        reset = 1'b0;
        step();
        chk("midreset_restart", {5'd0, seg, anode, frame_tick}, {5'd0, 7'h00, 3'b110, 1'b1});
        step_to(0);

        // Glyph sweep on the ones digit.
        for (int v = 0; v < 16; v++) begin
            set_in(4'h0, 4'h0, 4'(v), 1'b0);
            step_to(1);
            chk("glyph", {9'd0, seg}, {9'd0, glyph_tbl[v]});
            step_to(0);
        end

        // Random inputs arriving at arbitrary times, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0 && $urandom_range(0, 1) == 0)
                set_in(4'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 1'b1);
            reset = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;
        step_to(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
